// File: rtl/paint_px_writer.sv
`default_nettype none
// ============================================================================
// Module   : paint_px_writer
// Purpose  : Pen-position pixel writer with a req/ack framebuffer port and
//            a saturating step counter for the cursor-drawing controllers.
//            Define PAINT_CLAMP_EN to saturate pen moves at the edges
//            instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module paint_px_writer #(
   parameter int X_W    = 6,
   parameter int Y_W    = 6,
   parameter int DATA_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 init_pos,
   input  logic [X_W-1:0]       org_x,
   input  logic [Y_W-1:0]       org_y,
   input  logic                 paint,
   input  logic                 change_x,
   input  logic                 change_y,
   input  logic                 sum,
   input  logic [DATA_W-1:0]    px_data,
   input  logic                 plus,
   input  logic                 rst_cont,
   output logic [2:0]           step_cnt,
   output logic                 mem_we,
   output logic [X_W+Y_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   input  logic                 mem_ack,
   output logic [X_W-1:0]       pos_x,
   output logic [Y_W-1:0]       pos_y,
   output logic                 busy,
   output logic                 err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      MOVE  = 2'd2
   } state_t;

   localparam logic [X_W-1:0] X_ONE = X_W'(1);
   localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);
   localparam logic [X_W-1:0] X_MAX = '1;
   localparam logic [Y_W-1:0] Y_MAX = '1;

   state_t               state_q;
   logic [X_W-1:0]       pos_x_q, pos_x_d;
   logic [Y_W-1:0]       pos_y_q, pos_y_d;
   logic                 cx_q, cy_q, sum_q;
   logic [2:0]           step_q;
   logic                 we_q;
   logic [X_W+Y_W-1:0]   addr_q;
   logic [DATA_W-1:0]    wdata_q;
   logic                 err_q;

   // Post-move pen, applied only in MOVE from the command latched at paint.
   always_comb begin
      pos_x_d = pos_x_q;
      pos_y_d = pos_y_q;
      if (cx_q) begin
`ifdef PAINT_CLAMP_EN
         if (sum_q) begin
            if (pos_x_q != X_MAX) pos_x_d = pos_x_q + X_ONE;
         end else if (pos_x_q != '0) begin
            pos_x_d = pos_x_q - X_ONE;
         end
`else
         pos_x_d = sum_q ? (pos_x_q + X_ONE) : (pos_x_q - X_ONE);
`endif
      end
      if (cy_q) begin
`ifdef PAINT_CLAMP_EN
         if (sum_q) begin
            if (pos_y_q != Y_MAX) pos_y_d = pos_y_q + Y_ONE;
         end else if (pos_y_q != '0) begin
            pos_y_d = pos_y_q - Y_ONE;
         end
`else
         pos_y_d = sum_q ? (pos_y_q + Y_ONE) : (pos_y_q - Y_ONE);
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         pos_x_q <= '0;
         pos_y_q <= '0;
         cx_q    <= 1'b0;
         cy_q    <= 1'b0;
         sum_q   <= 1'b0;
         step_q  <= 3'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (rst_cont) begin
            step_q <= 3'd0;
         end else if (plus && (step_q != 3'd7)) begin
            step_q <= step_q + 3'd1;
         end

         case (state_q)
            IDLE: begin
               if (init_pos) begin
                  pos_x_q <= org_x;
                  pos_y_q <= org_y;
                  err_q   <= 1'b0;
               end else if (paint) begin
                  cx_q    <= change_x;
                  cy_q    <= change_y;
                  sum_q   <= sum;
                  addr_q  <= {pos_y_q, pos_x_q};
                  wdata_q <= px_data;
                  we_q    <= 1'b1;
                  state_q <= WRITE;
               end
            end
            WRITE: begin
               if (paint || init_pos) err_q <= 1'b1;
               if (mem_ack) begin
                  we_q    <= 1'b0;
                  state_q <= MOVE;
               end
            end
            MOVE: begin
               if (paint || init_pos) err_q <= 1'b1;
               pos_x_q <= pos_x_d;
               pos_y_q <= pos_y_d;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign step_cnt  = step_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign pos_x     = pos_x_q;
   assign pos_y     = pos_y_q;
   assign busy      = (state_q != IDLE);
   assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_paint_px_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_paint_px_writer
// Purpose  : Self-checking bench for paint_px_writer against a transaction
//            model; honours PAINT_CLAMP_EN for edge-move expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_paint_px_writer;

   localparam int X_W = 6;
   localparam int Y_W = 6;
   localparam int DW  = 8;
   localparam int XS  = 1 << X_W;
   localparam int YS  = 1 << Y_W;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            init_pos = 1'b0;
   logic [X_W-1:0]  org_x = '0;
   logic [Y_W-1:0]  org_y = '0;
   logic            paint = 1'b0, change_x = 1'b0, change_y = 1'b0, sum = 1'b0;
   logic [DW-1:0]   px_data = '0;
   logic            plus = 1'b0, rst_cont = 1'b0;
   logic [2:0]      step_cnt;
   logic            mem_we;
   logic [X_W+Y_W-1:0] mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic            mem_ack = 1'b1;
   logic [X_W-1:0]  pos_x;
   logic [Y_W-1:0]  pos_y;
   logic            busy, err;

   paint_px_writer #(.X_W(X_W), .Y_W(Y_W), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .init_pos(init_pos), .org_x(org_x), .org_y(org_y),
      .paint(paint), .change_x(change_x), .change_y(change_y), .sum(sum),
      .px_data(px_data), .plus(plus), .rst_cont(rst_cont), .step_cnt(step_cnt),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   // Transaction-level model: one outstanding paint = {write, then move}.
   int  m_x, m_y, m_step, m_addr, m_wdata;
   bit  m_err, m_we, m_writing, m_moving;
   bit  t_cx, t_cy, t_up;

   function automatic int mv(input int v, input bit c, input bit up, input int size);
      int n;
      if (!c) return v;
      n = up ? v + 1 : v - 1;
`ifdef PAINT_CLAMP_EN
      if (n < 0) n = 0;
      if (n >= size) n = size - 1;
      return n;
`else
      return (n + size) % size;
`endif
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_x = 0; m_y = 0; m_step = 0; m_addr = 0; m_wdata = 0;
         m_err = 0; m_we = 0; m_writing = 0; m_moving = 0;
      end else begin
         if (rst_cont) m_step = 0;
         else if (plus) m_step = (m_step + 1 > 7) ? 7 : m_step + 1;
         if (m_writing || m_moving) begin
            if (paint || init_pos) m_err = 1;
            if (m_moving) begin
               m_x = mv(m_x, t_cx, t_up, XS);
               m_y = mv(m_y, t_cy, t_up, YS);
               m_moving = 0;
            end else if (mem_ack) begin
               m_we = 0; m_writing = 0; m_moving = 1;
            end
         end else if (init_pos) begin
            m_x = org_x; m_y = org_y; m_err = 0;
         end else if (paint) begin
            t_cx = change_x; t_cy = change_y; t_up = sum;
            m_addr = m_y * XS + m_x; m_wdata = px_data;
            m_we = 1; m_writing = 1;
         end
      end
   end

   bit chk_en = 0;
   always @(negedge clk) begin
      if (chk_en) begin
         chk("mem_we",    mem_we,    m_we);
         chk("mem_addr",  mem_addr,  m_addr);
         chk("mem_wdata", mem_wdata, m_wdata);
         chk("pos_x",     pos_x,     m_x);
         chk("pos_y",     pos_y,     m_y);
         chk("step_cnt",  step_cnt,  m_step);
         chk("busy",      busy,      int'(m_writing || m_moving));
         chk("err",       err,       m_err);
      end
   end

   // Write-request monitor: one entry per rising mem_we.
   int wcount = 0;
   bit we_prev = 0;
   bit seen [0:XS*YS-1];
   always @(negedge clk) begin
      if (mem_we === 1'b1 && !we_prev) begin
         wcount++;
         seen[mem_addr] = 1'b1;
      end
      we_prev = (mem_we === 1'b1);
   end

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", int'(busy !== 1'b0), 0);
   endtask

   task automatic do_init(input int x, input int y);
      org_x = X_W'(x); org_y = Y_W'(y); init_pos = 1'b1;
      @(negedge clk);
      init_pos = 1'b0;
   endtask

   task automatic do_paint(input bit cx, input bit cy, input bit up, input int d);
      change_x = cx; change_y = cy; sum = up; px_data = DW'(d); paint = 1'b1;
      @(negedge clk);
      paint = 1'b0;
      wait_idle();
   endtask

   task automatic pulse_plus();
      plus = 1'b1;
      @(negedge clk);
      plus = 1'b0;
   endtask

   int sx, sy, saddr, sdata, n_ok;

   initial begin
      #1 rst = 1'b1;
      #2 chk_en = 1;
      @(negedge clk);
      chk("rst_pos_x", pos_x, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      @(negedge clk);

      // Init and a single +x paint.
      do_init(10, 20);
      chk("init_pos_x", pos_x, 10);
      chk("init_pos_y", pos_y, 20);
      chk("init_err", err, 0);
      change_x = 1; change_y = 0; sum = 1; px_data = 8'hFF; paint = 1;
      @(negedge clk);
      paint = 0;
      chk("first_we", mem_we, 1);
      chk("first_addr", mem_addr, 'h50A);
      chk("first_data", mem_wdata, 'hFF);
      @(negedge clk);
      @(negedge clk);
      chk("first_pos_x", pos_x, 11);
      chk("first_pos_y", pos_y, 20);
      chk("first_busy", busy, 0);

      // Cursor square: right, down, left, up, four steps each.
      do_init(10, 20);
      for (int i = 0; i < XS*YS; i++) seen[i] = 1'b0;
      wcount = 0;
      for (int e = 0; e < 4; e++) begin
         rst_cont = 1'b1;
         @(negedge clk);
         rst_cont = 1'b0;
         for (int s = 0; s < 4; s++) begin
            do_paint(e[0] == 1'b0, e[0] == 1'b1, e < 2, 16 * e + s);
            pulse_plus();
         end
         chk("edge_step_cnt", step_cnt, 4);
      end
      chk("square_writes", wcount, 16);
      n_ok = 0;
      for (int y = 20; y <= 24; y++)
         for (int x = 10; x <= 14; x++)
            if (seen[y * XS + x] && (x == 10 || x == 14 || y == 20 || y == 24)) n_ok++;
      chk("square_outline", n_ok, 16);
      chk("square_home_x", pos_x, 10);
      chk("square_home_y", pos_y, 20);

      // Edge moves.
      do_init(63, 0);
      do_paint(1, 1, 1, 8'h11);
`ifdef PAINT_CLAMP_EN
      chk("edge_diag_x", pos_x, 63);
      chk("edge_diag_y", pos_y, 1);
`else
      chk("edge_diag_x", pos_x, 0);
      chk("edge_diag_y", pos_y, 1);
`endif
      do_init(63, 0);
      do_paint(0, 1, 0, 8'h22);
`ifdef PAINT_CLAMP_EN
      chk("edge_down_y", pos_y, 0);
`else
      chk("edge_down_y", pos_y, 63);
`endif
      chk("edge_err", err, 0);

      // Slow ack with a paint dropped mid-write.
      do_init(5, 7);
      change_x = 0; change_y = 1; sum = 1; px_data = 8'hA5; paint = 1; mem_ack = 0;
      @(negedge clk);
      paint = 0;
      saddr = mem_addr; sdata = mem_wdata;
      chk("slow_addr", saddr, 7 * XS + 5);
      for (int i = 0; i < 6; i++) begin
         chk("slow_we_hold", mem_we, 1);
         chk("slow_addr_hold", mem_addr, saddr);
         chk("slow_data_hold", mem_wdata, sdata);
         if (i == 2) begin paint = 1; change_x = 1; px_data = 8'h3C; end
         if (i == 3) paint = 0;
         if (i == 5) mem_ack = 1;
         @(negedge clk);
      end
      wait_idle();
      repeat (3) @(negedge clk);
      chk("slow_err", err, 1);
      chk("slow_pos_x", pos_x, 5);
      chk("slow_pos_y", pos_y, 8);

      // Asynchronous reset in the middle of a write.
      pulse_plus();
      mem_ack = 0; change_x = 1; change_y = 0; sum = 1; px_data = 8'h77; paint = 1;
      @(negedge clk);
      paint = 0;
      #2 rst = 1'b1;
      #1;
      chk("arst_we", mem_we, 0);
      chk("arst_addr", mem_addr, 0);
      chk("arst_data", mem_wdata, 0);
      chk("arst_pos_x", pos_x, 0);
      chk("arst_busy", busy, 0);
      chk("arst_err", err, 0);
      chk("arst_step", step_cnt, 0);
      @(negedge clk);
      rst = 1'b0; mem_ack = 1;
      @(negedge clk);

      // Step counter saturation and rst_cont priority.
      repeat (10) pulse_plus();
      chk("step_sat", step_cnt, 7);
      plus = 1; rst_cont = 1;
      @(negedge clk);
      plus = 0; rst_cont = 0;
      chk("step_clr_prio", step_cnt, 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         init_pos = ($urandom_range(0, 19) == 0);
         org_x    = X_W'($urandom);
         org_y    = Y_W'($urandom);
         paint    = ($urandom_range(0, 2) == 0);
         change_x = 1'($urandom);
         change_y = 1'($urandom);
         sum      = 1'($urandom);
         px_data  = DW'($urandom);
         plus     = 1'($urandom);
         rst_cont = ($urandom_range(0, 7) == 0);
         mem_ack  = ($urandom_range(0, 9) < 7);
         @(negedge clk);
      end
      init_pos = 0; paint = 0; plus = 0; rst_cont = 0; mem_ack = 1;
      wait_idle();
      repeat (3) @(negedge clk);
      chk_en = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
